// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the Picorv32-to-SRAM wait-state bridge.
package mem_bridge_pkg;

  // Bridge transfer sequencing
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Address decode result, latched when a request is accepted
  typedef enum logic [1:0] {
    RGN_RAM      = 2'd0,
    RGN_CONSOLE  = 2'd1,
    RGN_PASS     = 2'd2,
    RGN_UNMAPPED = 2'd3
  } region_t;

  // Galois feedback taps for the 16-bit right-shifting wait-state LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bridge_lfsr16.sv
// Free-running 16-bit Galois LFSR supplying pseudo-random wait counts.
module bridge_lfsr16
  import mem_bridge_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Advance one step every non-reset cycle; a zero seed would lock the sequence at zero
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= SEED;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/mem_wait_bridge.sv
// Picorv32 native-port bridge: random wait states, SRAM / console / pass-flag decode,
// sticky pass and bus-error flags.
module mem_wait_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 32768,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC   = 32'd123456789,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [1:0]  MAX_WAIT     = 2'd3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wait_en,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic [31:0] core_rdata,
  output logic        ram_valid,
  input  logic        ram_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        tests_passed,
  output logic        bus_error
);

  // Byte size of the SRAM window, one bit wider so the full 4 GiB space cannot wrap
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

  state_t      r_state;
  region_t     r_rgn;
  logic [1:0]  r_wcnt;
  logic        r_abort;
  logic        r_core_ready;
  logic [31:0] r_core_rdata;
  logic        r_ram_valid;
  logic        r_console_valid;
  logic [7:0]  r_console_data;
  logic        r_tests_passed;
  logic        r_bus_error;

  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;
  region_t     w_rgn;
  logic [1:0]  w_wcnt_load;
  logic        w_abort;
  logic        w_pass_hit;

  bridge_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock   (clock),
    .resetn  (resetn),
    .o_state (w_lfsr)
  );

  // Only the two low LFSR bits pick the wait count
  assign w_unused_lfsr = ^w_lfsr[15:2];

  // Region decode on the live request; address bits [1:0] never take part
  always_comb begin
    w_rgn = RGN_UNMAPPED;
    if ({1'b0, core_addr} < RAM_BYTES) begin
      w_rgn = RGN_RAM;
    end else if (core_addr[31:2] == CONSOLE_ADDR[31:2]) begin
      w_rgn = RGN_CONSOLE;
    end else if (core_addr[31:2] == PASS_ADDR[31:2]) begin
      w_rgn = RGN_PASS;
    end
  end

  assign w_wcnt_load = wait_en ? (w_lfsr[1:0] & MAX_WAIT) : 2'd0;

  // A transfer is abandoned once the core has let go of valid, even if valid returns later
  assign w_abort    = !core_valid || r_abort;
  assign w_pass_hit = (core_wstrb == 4'hF) && (core_wdata == PASS_MAGIC);

  // Transfer sequencer with all core/ram/console outputs and sticky flags registered
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state         <= IDLE;
      r_rgn           <= RGN_RAM;
      r_wcnt          <= 2'd0;
      r_abort         <= 1'b0;
      r_core_ready    <= 1'b0;
      r_core_rdata    <= 32'd0;
      r_ram_valid     <= 1'b0;
      r_console_valid <= 1'b0;
      r_console_data  <= 8'd0;
      r_tests_passed  <= 1'b0;
      r_bus_error     <= 1'b0;
    end else begin
      r_core_ready    <= 1'b0;
      r_console_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_abort <= 1'b0;
          if (core_valid) begin
            r_rgn  <= w_rgn;
            r_wcnt <= w_wcnt_load;
            if (w_wcnt_load != 2'd0) begin
              r_state <= WAIT;
            end else begin
              r_state     <= ACCESS;
              r_ram_valid <= (w_rgn == RGN_RAM);
            end
          end
        end

        WAIT: begin
          r_wcnt <= r_wcnt - 2'd1;
          if (!core_valid) begin
            r_bus_error <= 1'b1;
            r_state     <= IDLE;
          end else if (r_wcnt == 2'd1) begin
            r_state     <= ACCESS;
            r_ram_valid <= (r_rgn == RGN_RAM);
          end
        end

        ACCESS: begin
          if (!core_valid) begin
            r_bus_error <= 1'b1;
          end
          case (r_rgn)
            RGN_RAM: begin
              // An SRAM request already issued must finish before the bridge can idle
              if (!core_valid) begin
                r_abort <= 1'b1;
              end
              if (r_ram_valid && ram_ready) begin
                r_ram_valid <= 1'b0;
                if (w_abort) begin
                  r_state <= IDLE;
                end else begin
                  r_core_rdata <= ram_rdata;
                  r_core_ready <= 1'b1;
                  r_state      <= RESP;
                end
              end
            end

            RGN_CONSOLE: begin
              if (w_abort) begin
                r_state <= IDLE;
              end else begin
                if (core_wstrb[0]) begin
                  r_console_valid <= 1'b1;
                  r_console_data  <= core_wdata[7:0];
                end
                r_core_rdata <= 32'd0;
                r_core_ready <= 1'b1;
                r_state      <= RESP;
              end
            end

            RGN_PASS: begin
              if (w_abort) begin
                r_state <= IDLE;
              end else begin
                if (w_pass_hit) begin
                  r_tests_passed <= 1'b1;
                end
                r_core_rdata <= (core_wstrb == 4'h0) ? {31'd0, r_tests_passed} : 32'd0;
                r_core_ready <= 1'b1;
                r_state      <= RESP;
              end
            end

            RGN_UNMAPPED: begin
              if (w_abort) begin
                r_state <= IDLE;
              end else begin
                r_bus_error  <= 1'b1;
                r_core_rdata <= 32'd0;
                r_core_ready <= 1'b1;
                r_state      <= RESP;
              end
            end
          endcase
        end

        RESP: begin
          // core_ready is visible this cycle; valid must still be held until the edge
          if (!core_valid) begin
            r_bus_error <= 1'b1;
          end
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign core_ready    = r_core_ready;
  assign core_rdata    = r_core_rdata;
  assign ram_valid     = r_ram_valid;
  assign ram_addr      = core_addr;
  assign ram_wdata     = core_wdata;
  assign ram_wstrb     = core_wstrb;
  assign console_valid = r_console_valid;
  assign console_data  = r_console_data;
  assign tests_passed  = r_tests_passed;
  assign bus_error     = r_bus_error;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Testbench for mem_wait_bridge: directed vector table, corner sequences and a
// randomized wait-state run checked against an independent LFSR/memory model.
module tb_mem_wait_bridge;

  logic        clock = 1'b0;
  logic        resetn;
  logic        wait_en;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [31:0] core_rdata;
  logic        ram_valid;
  logic        ram_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        tests_passed;
  logic        bus_error;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  mem_wait_bridge dut (
    .clock         (clock),
    .resetn        (resetn),
    .wait_en       (wait_en),
    .core_valid    (core_valid),
    .core_ready    (core_ready),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_wstrb    (core_wstrb),
    .core_rdata    (core_rdata),
    .ram_valid     (ram_valid),
    .ram_ready     (ram_ready),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_wstrb     (ram_wstrb),
    .ram_rdata     (ram_rdata),
    .console_valid (console_valid),
    .console_data  (console_data),
    .tests_passed  (tests_passed),
    .bus_error     (bus_error)
  );

  // SRAM model: 1024 words, combinational read, byte-strobed write on handshake
  logic [31:0] mem [0:1023];
  assign ram_rdata = mem[ram_addr[11:2]];
  always @(posedge clock) begin
    if (ram_valid && ram_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wstrb[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Event counters sampled away from the active edge
  int          cons_cnt = 0;
  int          rv_cnt   = 0;
  int          rdy_cnt  = 0;
  logic [7:0]  cons_last = 8'd0;
  always @(negedge clock) begin
    if (console_valid) begin
      cons_cnt  = cons_cnt + 1;
      cons_last = console_data;
    end
    if (ram_valid)  rv_cnt  = rv_cnt + 1;
    if (core_ready) rdy_cnt = rdy_cnt + 1;
  end

  // Reference wait-state generator: Galois right shift with taps 0xB400, seed 0xACE1
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  logic [15:0] ref_lfsr;
  always @(posedge clock) ref_lfsr <= !resetn ? 16'hACE1 : lfsr_step(ref_lfsr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One core transfer starting at a negedge; returns latency in cycles from valid to ready
  task automatic xfer(input string nm, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int stalls,
                      output logic [31:0] rd, output int lat);
    int left;
    left = stalls;
    lat  = -1;
    rd   = 32'd0;
    core_addr  = a;
    core_wdata = d;
    core_wstrb = s;
    core_valid = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (ram_valid && left > 0) begin
        ram_ready = 1'b0;
        left--;
      end else begin
        ram_ready = 1'b1;
      end
      if (core_ready) begin
        lat = n;
        rd  = core_rdata;
        break;
      end
    end
    if (lat < 0) begin
      n_total++;
      $display("FAIL %s_timeout: no core_ready within 40 cycles", nm);
    end
    @(negedge clock);
    core_valid = 1'b0;
    ram_ready  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn     = 1'b0;
    core_valid = 1'b0;
    ram_ready  = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_cons;
    logic [7:0]  exp_cd;
    logic        exp_pass;
    logic        exp_err;
    int          exp_rv;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  logic [31:0] exp_mem [16];

  initial begin
    logic [31:0] rd;
    int          lat;
    int          c0, r0, y0, k;
    bit          found;

    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, c0, r0, y0, k, idx;
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          found;

    //         addr           wdata          strb   chk rd          cons cd     pass  err  rv
    tbl[0]  = '{32'h0000_0100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 8'h00, 1'b0, 1'b0, 1};
    tbl[1]  = '{32'h0000_0100, 32'h0,        4'h0, 1, 32'hDEADBEEF, 0, 8'h00, 1'b0, 1'b0, 1};
    tbl[2]  = '{32'h0000_0104, 32'h12345678, 4'hF, 0, 32'h0,        0, 8'h00, 1'b0, 1'b0, 1};
    tbl[3]  = '{32'h0000_0104, 32'hAABBCCDD, 4'h2, 0, 32'h0,        0, 8'h00, 1'b0, 1'b0, 1};
    tbl[4]  = '{32'h0000_0106, 32'h0,        4'h0, 1, 32'h1234CC78, 0, 8'h00, 1'b0, 1'b0, 1};
    tbl[5]  = '{32'h1000_0000, 32'h0000_0041,4'h1, 0, 32'h0,        1, 8'h41, 1'b0, 1'b0, 0};
    tbl[6]  = '{32'h1000_0000, 32'h0,        4'h0, 1, 32'h0,        0, 8'h00, 1'b0, 1'b0, 0};
    tbl[7]  = '{32'h1000_0003, 32'h0000_5A5A,4'h2, 0, 32'h0,        0, 8'h00, 1'b0, 1'b0, 0};
    tbl[8]  = '{32'h2000_0000, 32'h0,        4'hF, 0, 32'h0,        0, 8'h00, 1'b0, 1'b0, 0};
    tbl[9]  = '{32'h2000_0000, 32'h0,        4'h0, 1, 32'h0,        0, 8'h00, 1'b0, 1'b0, 0};
    tbl[10] = '{32'h2000_0000, 32'h075BCD15, 4'h7, 0, 32'h0,        0, 8'h00, 1'b0, 1'b0, 0};
    tbl[11] = '{32'h2000_0000, 32'h075BCD15, 4'hF, 0, 32'h0,        0, 8'h00, 1'b1, 1'b0, 0};
    tbl[12] = '{32'h2000_0002, 32'h0,        4'h0, 1, 32'h1,        0, 8'h00, 1'b1, 1'b0, 0};
    tbl[13] = '{32'h0001_FFFC, 32'hCAFEF00D, 4'hF, 0, 32'h0,        0, 8'h00, 1'b1, 1'b0, 1};
    tbl[14] = '{32'h0001_FFFC, 32'h0,        4'h0, 1, 32'hCAFEF00D, 0, 8'h00, 1'b1, 1'b0, 1};
    tbl[15] = '{32'h0002_0000, 32'h0,        4'h0, 1, 32'h0,        0, 8'h00, 1'b1, 1'b1, 0};
    tbl[16] = '{32'h3000_0000, 32'h0,        4'h0, 1, 32'h0,        0, 8'h00, 1'b1, 1'b1, 0};
    tbl[17] = '{32'h0000_0100, 32'h0,        4'h0, 1, 32'hDEADBEEF, 0, 8'h00, 1'b1, 1'b1, 1};

    resetn = 1'b0; wait_en = 1'b0; core_valid = 1'b0; ram_ready = 1'b1;
    core_addr = 32'd0; core_wdata = 32'd0; core_wstrb = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_core_ready",    {31'd0, core_ready},    32'd0);
    chk("rst_ram_valid",     {31'd0, ram_valid},     32'd0);
    chk("rst_console_valid", {31'd0, console_valid}, 32'd0);
    chk("rst_tests_passed",  {31'd0, tests_passed},  32'd0);
    chk("rst_bus_error",     {31'd0, bus_error},     32'd0);
    chk("rst_core_rdata",    core_rdata,             32'd0);
    chk("rst_console_data",  {24'd0, console_data},  32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Directed vectors, zero-wait
    for (int i = 0; i < NV; i++) begin
      c0 = cons_cnt; r0 = rv_cnt;
      xfer($sformatf("v%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 0, rd, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d_console_pulses", i), 32'(cons_cnt - c0), 32'(tbl[i].exp_cons));
      if (tbl[i].exp_cons > 0) chk($sformatf("v%0d_console_data", i), {24'd0, cons_last}, {24'd0, tbl[i].exp_cd});
      chk($sformatf("v%0d_tests_passed", i), {31'd0, tests_passed}, {31'd0, tbl[i].exp_pass});
      chk($sformatf("v%0d_bus_error", i), {31'd0, bus_error}, {31'd0, tbl[i].exp_err});
      chk($sformatf("v%0d_ram_valid_cycles", i), 32'(rv_cnt - r0), 32'(tbl[i].exp_rv));
    end

    repeat (100) @(negedge clock);
    chk("pass_sticky_100", {31'd0, tests_passed}, 32'd1);

    // SRAM stall: three cycles of ram_ready low lengthen the transfer by three
    r0 = rv_cnt;
    xfer("stall", 32'h0000_0100, 32'h0, 4'h0, 3, rd, lat);
    chk("stall_latency", 32'(lat), 32'd5);
    chk("stall_rdata", rd, 32'hDEADBEEF);
    chk("stall_ram_valid_cycles", 32'(rv_cnt - r0), 32'd4);

    // Drop core_valid while waiting: error, no ready, no SRAM request
    do_reset();
    wait_en = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (ref_lfsr[1:0] != 2'd0) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!found) begin
      n_total++;
      $display("FAIL wait_drop_setup: no nonzero wait count within 64 cycles");
    end
    y0 = rdy_cnt; r0 = rv_cnt;
    core_addr = 32'h0000_0100; core_wstrb = 4'h0; core_valid = 1'b1;
    @(negedge clock);
    core_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("wait_drop_bus_error", {31'd0, bus_error}, 32'd1);
    chk("wait_drop_no_ready", 32'(rdy_cnt - y0), 32'd0);
    chk("wait_drop_no_ram", 32'(rv_cnt - r0), 32'd0);
    wait_en = 1'b0;
    xfer("after_wait_drop", 32'h0000_0104, 32'h0, 4'h0, 0, rd, lat);
    chk("after_wait_drop_latency", 32'(lat), 32'd2);
    chk("after_wait_drop_rdata", rd, 32'h1234CC78);

    // Drop core_valid in ACCESS with SRAM stalled: request completes, result discarded
    do_reset();
    y0 = rdy_cnt;
    ram_ready = 1'b0;
    core_addr = 32'h0000_0100; core_wstrb = 4'h0; core_valid = 1'b1;
    @(negedge clock);
    chk("acc_drop_ram_valid_on", {31'd0, ram_valid}, 32'd1);
    core_valid = 1'b0;
    @(negedge clock);
    chk("acc_drop_bus_error", {31'd0, bus_error}, 32'd1);
    chk("acc_drop_ram_still_valid", {31'd0, ram_valid}, 32'd1);
    ram_ready = 1'b1;
    @(negedge clock);
    chk("acc_drop_ram_released", {31'd0, ram_valid}, 32'd0);
    repeat (3) @(negedge clock);
    chk("acc_drop_no_ready", 32'(rdy_cnt - y0), 32'd0);
    xfer("after_acc_drop", 32'h0000_0100, 32'h0, 4'h0, 0, rd, lat);
    chk("after_acc_drop_latency", 32'(lat), 32'd2);

    // Reset in the middle of a stalled SRAM access clears everything
    xfer("pass_again", 32'h2000_0000, 32'h075BCD15, 4'hF, 0, rd, lat);
    chk("pass_again_flag", {31'd0, tests_passed}, 32'd1);
    ram_ready = 1'b0;
    core_addr = 32'h0000_0100; core_wstrb = 4'h0; core_valid = 1'b1;
    @(negedge clock);
    chk("mid_rst_ram_valid_on", {31'd0, ram_valid}, 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk("mid_rst_ram_valid", {31'd0, ram_valid}, 32'd0);
    chk("mid_rst_core_ready", {31'd0, core_ready}, 32'd0);
    chk("mid_rst_tests_passed", {31'd0, tests_passed}, 32'd0);
    chk("mid_rst_bus_error", {31'd0, bus_error}, 32'd0);
    core_valid = 1'b0; ram_ready = 1'b1; resetn = 1'b1;
    @(negedge clock);
    xfer("after_mid_rst", 32'h0000_0100, 32'h0, 4'h0, 0, rd, lat);
    chk("after_mid_rst_latency", 32'(lat), 32'd2);
    chk("after_mid_rst_rdata", rd, 32'hDEADBEEF);

    // Randomized back-to-back traffic with wait states, checked against model
    do_reset();
    wait_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      idx = (i < 16) ? i : int'($urandom_range(0, 15));
      a   = 32'h0000_0200 + 32'(idx * 4) + 32'($urandom_range(0, 3));
      d   = $urandom;
      if (i < 16) s = 4'hF;
      else if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(1, 15));
      else s = 4'h0;
      k = int'(ref_lfsr[1:0]);
      xfer($sformatf("rnd%0d", i), a, d, s, 0, rd, lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(2 + k));
      if (s == 4'h0) begin
        chk($sformatf("rnd%0d_rdata", i), rd, exp_mem[idx]);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    chk("rnd_bus_error", {31'd0, bus_error}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
